// File: rtl/disk_uart_rx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | disk_uart_rx_if : serial-in / sector-buffer-write bundle              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface disk_uart_rx_if #(
  parameter int ADDR_W = 7
);
  logic              RxD;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              sector_done;
  logic              busy;
  logic              frame_err;

  modport master (
    output RxD, start,
    input  wr_en, wr_addr, wr_data, sector_done, busy, frame_err
  );

  modport slave (
    input  RxD, start,
    output wr_en, wr_addr, wr_data, sector_done, busy, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/disk_uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | disk_uart_rx : 8N1 receiver packing bytes into sector-buffer words    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module disk_uart_rx #(
  parameter int CLK_DIV = 434,
  parameter int WORDS   = 128,
  parameter int ADDR_W  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  disk_uart_rx_if.slave bus
);

  localparam int                TMR_W       = $clog2(CLK_DIV);
  localparam logic [TMR_W-1:0]  HALF_RELOAD = TMR_W'(CLK_DIV / 2 - 1);
  localparam logic [TMR_W-1:0]  FULL_RELOAD = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  logic             sync1_q, sync2_q, rxs;
  logic [1:0]       settle_q;
  logic             line_hi_q;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tick;
  logic             byte_ok;
  logic             stop_bad;

  logic [23:0]       lanes_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic              busy_q;
  logic              frame_err_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              sector_done_q;

  // line_hi_q gates start detection until the synchronizer holds real
  // line samples and the line has been seen idle, so a frame cut by reset
  // is never picked up half-way through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      settle_q  <= 2'd0;
      line_hi_q <= 1'b0;
    end else begin
      sync1_q <= bus.RxD;
      sync2_q <= sync1_q;
      if (!settle_q[1]) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q[1] && sync2_q) begin
        line_hi_q <= 1'b1;
      end
    end
  end

  assign rxs  = sync2_q;
  assign tick = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
    end else begin
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (line_hi_q && !rxs) begin
          timer_d = HALF_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          timer_d = timer_q - TMR_ONE;
        end else if (rxs) begin
          state_d = S_IDLE;
        end else begin
          timer_d  = FULL_RELOAD;
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (!tick) begin
          timer_d = timer_q - TMR_ONE;
        end else begin
          shreg_d = {rxs, shreg_q[7:1]};
          timer_d = FULL_RELOAD;
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (!tick) begin
          timer_d = timer_q - TMR_ONE;
        end else begin
          state_d = rxs ? S_IDLE : S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ok  = 1'b0;
    stop_bad = 1'b0;
    if (state_q == S_STOP && tick) begin
      byte_ok  = rxs;
      stop_bad = !rxs;
    end
  end

  // A start coinciding with a registered write lets that write stand but
  // overrides the end-of-sector completion, since the transfer restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q       <= 24'd0;
      byte_idx_q    <= 2'd0;
      word_idx_q    <= '0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 32'd0;
      sector_done_q <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      sector_done_q <= 1'b0;

      if (wr_en_q && (wr_addr_q == LAST_WORD) && !bus.start) begin
        sector_done_q <= 1'b1;
        busy_q        <= 1'b0;
      end

      if (bus.start) begin
        byte_idx_q <= 2'd0;
        word_idx_q <= '0;
        busy_q     <= 1'b1;
      end else if (busy_q && byte_ok) begin
        case (byte_idx_q)
          2'd0:    lanes_q[7:0]   <= shreg_q;
          2'd1:    lanes_q[15:8]  <= shreg_q;
          2'd2:    lanes_q[23:16] <= shreg_q;
          default: begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= word_idx_q;
            wr_data_q  <= {shreg_q, lanes_q};
            word_idx_q <= (word_idx_q == LAST_WORD) ? '0 : word_idx_q + ADDR_ONE;
          end
        endcase
        byte_idx_q <= byte_idx_q + 2'd1;
      end

      if (stop_bad) begin
        frame_err_q <= 1'b1;
      end else if (bus.start) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.sector_done = sector_done_q;
  assign bus.busy        = busy_q;
  assign bus.frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_disk_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_disk_uart_rx : randomized self-checking bench for disk_uart_rx     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_disk_uart_rx;

  localparam int CLK_DIV = 8;
  localparam int WORDS   = 4;
  localparam int ADDR_W  = 2;
  // drive edge -> capture (1) + synchronizer (2) + half bit + nine full bits
  localparam int STOP_LAT = 1 + 2 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t_bg;

  disk_uart_rx_if #(.ADDR_W(ADDR_W)) bus ();

  disk_uart_rx #(
    .CLK_DIV (CLK_DIV),
    .WORDS   (WORDS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                wq_cyc[$];
  int                sd_cyc[$];

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_cyc.push_back(cyc);
    end
    if (bus.sector_done === 1'b1) sd_cyc.push_back(cyc);
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); sd_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic arm();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t0);
    t0 = cyc;
    bus.RxD = 1'b0; tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin bus.RxD = b[i]; tick(CLK_DIV); end
    bus.RxD = stop_bit; tick(CLK_DIV);
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic test_reset();
    bus.RxD = 1'b1; bus.start = 1'b0; rst_n = 1'b0;
    tick(3); rst_n = 1'b1; tick(1);
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
    checks++; if (bus.sector_done !== 1'b0) begin failures++; $display("FAIL reset_sector_done got %b want 0", bus.sector_done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    clear_mon(); tick(20);
    checks++; if (wq_data.size() != 0 || sd_cyc.size() != 0) begin failures++; $display("FAIL idle_quiet got writes=%0d done=%0d want 0/0", wq_data.size(), sd_cyc.size()); end
    arm();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL arm_busy got %b want 1", bus.busy); end
  endtask

  task automatic test_single_word();
    logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int t0;
    arm(); clear_mon();
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1, t0);
    tick(10);
    checks++; if (wq_data.size() != 1) begin failures++; $display("FAIL single_count got %0d want 1", wq_data.size()); end
    if (wq_data.size() > 0) begin
      checks++; if (wq_data[0] !== 32'h44332211) begin failures++; $display("FAIL single_data got %h want 44332211", wq_data[0]); end
      checks++; if (wq_addr[0] !== '0) begin failures++; $display("FAIL single_addr got %0d want 0", wq_addr[0]); end
      checks++; if (wq_cyc[0] != t0 + STOP_LAT) begin failures++; $display("FAIL single_latency got %0d want %0d", wq_cyc[0], t0 + STOP_LAT); end
    end
    checks++; if (bus.wr_data !== 32'h44332211) begin failures++; $display("FAIL single_hold got %h want 44332211", bus.wr_data); end
  endtask

  task automatic test_sector();
    logic [7:0] b[4*WORDS];
    int t0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4 * WORDS; i++) b[i] = (pass == 0) ? 8'(i) : 8'($urandom);
      arm(); clear_mon();
      for (int i = 0; i < 4 * WORDS; i++) send_byte(b[i], 1'b1, t0);
      tick(10);
      checks++; if (wq_data.size() != WORDS) begin failures++; $display("FAIL sector%0d_count got %0d want %0d", pass, wq_data.size(), WORDS); end
      for (int j = 0; j < WORDS && j < wq_data.size(); j++) begin
        checks++; if (wq_addr[j] !== ADDR_W'(j)) begin failures++; $display("FAIL sector%0d_addr%0d got %0d want %0d", pass, j, wq_addr[j], j); end
        checks++; if (wq_data[j] !== pack4(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3])) begin
          failures++; $display("FAIL sector%0d_data%0d got %h want %h", pass, j, wq_data[j], pack4(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]));
        end
      end
      checks++; if (sd_cyc.size() != 1) begin failures++; $display("FAIL sector%0d_done_count got %0d want 1", pass, sd_cyc.size()); end
      if (sd_cyc.size() > 0) begin
        checks++; if (sd_cyc[0] != t0 + STOP_LAT + 1) begin failures++; $display("FAIL sector%0d_done_time got %0d want %0d", pass, sd_cyc[0], t0 + STOP_LAT + 1); end
      end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sector%0d_busy got %b want 0", pass, bus.busy); end
    end
  endtask

  task automatic test_disarm_rearm();
    logic [7:0] b[4];
    int t0;
    clear_mon();
    send_byte(8'hAA, 1'b1, t0); tick(10);
    checks++; if (wq_data.size() != 0) begin failures++; $display("FAIL disarmed_write got %0d want 0", wq_data.size()); end
    arm();
    send_byte(8'($urandom), 1'b1, t0);
    send_byte(8'($urandom), 1'b1, t0);
    arm();
    for (int i = 0; i < 4; i++) begin b[i] = 8'($urandom); send_byte(b[i], 1'b1, t0); end
    tick(10);
    checks++; if (wq_data.size() != 1) begin failures++; $display("FAIL rearm_count got %0d want 1", wq_data.size()); end
    if (wq_data.size() > 0) begin
      checks++; if (wq_data[0] !== pack4(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL rearm_data got %h want %h", wq_data[0], pack4(b[0], b[1], b[2], b[3])); end
      checks++; if (wq_addr[0] !== '0) begin failures++; $display("FAIL rearm_addr got %0d want 0", wq_addr[0]); end
    end
  endtask

  task automatic test_glitch_frame_err();
    logic [7:0] b[4];
    int t0;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    arm(); clear_mon();
    send_byte(b[0], 1'b1, t0);
    bus.RxD = 1'b0; tick(3); bus.RxD = 1'b1; tick(20);
    send_byte(b[1], 1'b1, t0);
    send_byte(8'($urandom), 1'b0, t0);
    tick(40);
    checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL frame_err_set got %b want 1", bus.frame_err); end
    bus.RxD = 1'b1; tick(30);
    send_byte(b[2], 1'b1, t0);
    send_byte(b[3], 1'b1, t0);
    tick(10);
    checks++; if (wq_data.size() != 1) begin failures++; $display("FAIL glitch_count got %0d want 1", wq_data.size()); end
    if (wq_data.size() > 0) begin
      checks++; if (wq_data[0] !== pack4(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL glitch_data got %h want %h", wq_data[0], pack4(b[0], b[1], b[2], b[3])); end
    end
    checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL frame_err_sticky got %b want 1", bus.frame_err); end
    arm();
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL frame_err_clear got %b want 0", bus.frame_err); end
  endtask

  task automatic test_start_collision();
    logic [7:0] b[12];
    int t0, t3;
    for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
    arm(); clear_mon();
    for (int i = 0; i < 7; i++) send_byte(b[i], 1'b1, t0);
    fork
      send_byte(b[7], 1'b1, t3);
      begin
        repeat (STOP_LAT) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    join
    for (int i = 8; i < 12; i++) send_byte(b[i], 1'b1, t0);
    tick(10);
    checks++; if (wq_data.size() != 3) begin failures++; $display("FAIL collide_count got %0d want 3", wq_data.size()); end
    if (wq_data.size() == 3) begin
      checks++; if (wq_addr[1] !== ADDR_W'(1) || wq_data[1] !== pack4(b[4], b[5], b[6], b[7])) begin
        failures++; $display("FAIL collide_write got addr %0d data %h want addr 1 data %h", wq_addr[1], wq_data[1], pack4(b[4], b[5], b[6], b[7]));
      end
      checks++; if (wq_cyc[1] != t3 + STOP_LAT) begin failures++; $display("FAIL collide_time got %0d want %0d", wq_cyc[1], t3 + STOP_LAT); end
      checks++; if (wq_addr[2] !== '0 || wq_data[2] !== pack4(b[8], b[9], b[10], b[11])) begin
        failures++; $display("FAIL collide_after got addr %0d data %h want addr 0 data %h", wq_addr[2], wq_data[2], pack4(b[8], b[9], b[10], b[11]));
      end
    end
    checks++; if (bus.busy !== 1'b1 || sd_cyc.size() != 0) begin failures++; $display("FAIL collide_busy got busy=%b done=%0d want 1/0", bus.busy, sd_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[4];
    int t0;
    arm();
    send_byte(8'($urandom), 1'b0, t0);
    bus.RxD = 1'b1; tick(20);
    send_byte(8'($urandom), 1'b1, t0);
    fork
      send_byte(8'h00, 1'b1, t_bg);
    join_none
    tick(30);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin failures++; $display("FAIL midreset_flags got busy=%b ferr=%b want 0/0", bus.busy, bus.frame_err); end
    checks++; if (bus.wr_addr !== '0 || bus.wr_data !== 32'd0 || bus.wr_en !== 1'b0 || bus.sector_done !== 1'b0) begin
      failures++; $display("FAIL midreset_bus got addr=%0d data=%h en=%b done=%b want zeros", bus.wr_addr, bus.wr_data, bus.wr_en, bus.sector_done);
    end
    tick(4); rst_n = 1'b1;
    tick(60);
    clear_mon(); arm();
    for (int i = 0; i < 4; i++) begin b[i] = 8'($urandom); send_byte(b[i], 1'b1, t0); end
    tick(10);
    checks++; if (wq_data.size() != 1) begin failures++; $display("FAIL postreset_count got %0d want 1", wq_data.size()); end
    if (wq_data.size() > 0) begin
      checks++; if (wq_addr[0] !== '0 || wq_data[0] !== pack4(b[0], b[1], b[2], b[3])) begin
        failures++; $display("FAIL postreset_write got addr %0d data %h want addr 0 data %h", wq_addr[0], wq_data[0], pack4(b[0], b[1], b[2], b[3]));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_sector();
    test_disarm_rearm();
    test_glitch_frame_err();
    test_start_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
